// File: rtl/oc8051_cxrom_pkg.sv
// ============================================================================
// Module      : oc8051_cxrom_pkg
// Description : Shared widths and types for the dual-port code-ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oc8051_cxrom_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } port_st_e;

endpackage

`default_nettype wire

// File: rtl/oc8051_rr_arb2.sv
// ============================================================================
// Module      : oc8051_rr_arb2
// Description : Two-way round-robin arbiter; ptr_i names the favoured port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oc8051_rr_arb2
    import oc8051_cxrom_pkg::*;
(
    input  logic [1:0] elig_i,
    input  port_idx_e  ptr_i,
    output logic [1:0] gnt_o,
    output logic       upd_o,
    output port_idx_e  ptr_nxt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (elig_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_i == PORT0) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // The loser of this grant becomes the favoured port next time.
    assign upd_o     = |elig_i;
    assign ptr_nxt_o = gnt_o[0] ? PORT1 : PORT0;

endmodule

`default_nettype wire

// File: rtl/oc8051_cxrom_arb.sv
// ============================================================================
// Module      : oc8051_cxrom_arb
// Description : Round-robin arbiter sharing one combinational code ROM
//               between two read ports; ack one cycle after grant.
//               Optional grant counters when CXROM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oc8051_cxrom_arb
    import oc8051_cxrom_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 65536,
    parameter int          ADDR_W    = c_ADDR_W,
    parameter int          DATA_W    = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] data0,
    output logic              err0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] data1,
    output logic              err1,
`ifdef CXROM_ARB_STATS_EN
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic              run_q;
    port_idx_e         ptr_q;
    port_idx_e         ptr_d;
    logic              ptr_upd;
    logic [1:0]        w_req;
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic [1:0]        w_ack;
    logic [1:0]        w_err;
    logic [DATA_W-1:0] w_data [2];
    logic              w_oor;
`ifdef CXROM_ARB_STATS_EN
    logic [15:0]       w_cnt [2];
`endif

    assign w_req = {req1, req0};

    // Holds off arbitration until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ptr_q <= PORT0;
        else if (ptr_upd) ptr_q <= ptr_d;
    end

    oc8051_rr_arb2 u_arb (
        .elig_i    (w_elig),
        .ptr_i     (ptr_q),
        .gnt_o     (w_gnt),
        .upd_o     (ptr_upd),
        .ptr_nxt_o (ptr_d)
    );

    assign rom_addr = w_gnt[1] ? addr1 : addr0;
    assign w_oor    = (32'(rom_addr) >= ROM_DEPTH);

    for (genvar i = 0; i < 2; i++) begin : g_port
        port_st_e          st_q;
        logic              ack_q;
        logic              err_q;
        logic [DATA_W-1:0] data_q;

        assign w_elig[i] = run_q & w_req[i] & (st_q == ST_IDLE);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q   <= ST_IDLE;
                ack_q  <= 1'b0;
                err_q  <= 1'b0;
                data_q <= '0;
            end else begin
                ack_q <= 1'b0;
                case (st_q)
                    ST_IDLE: begin
                        if (w_gnt[i]) begin
                            st_q   <= ST_ACK;
                            ack_q  <= 1'b1;
                            err_q  <= w_oor;
                            data_q <= w_oor ? '0 : rom_data;
                        end
                    end
                    ST_ACK:  st_q <= ST_IDLE;
                    default: st_q <= ST_IDLE;
                endcase
            end
        end

        assign w_ack[i]  = ack_q;
        assign w_err[i]  = err_q;
        assign w_data[i] = data_q;

`ifdef CXROM_ARB_STATS_EN
        logic [15:0] cnt_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                             cnt_q <= '0;
            else if (w_gnt[i] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end

        assign w_cnt[i] = cnt_q;
`endif
    end

    assign ack0  = w_ack[0];
    assign ack1  = w_ack[1];
    assign err0  = w_err[0];
    assign err1  = w_err[1];
    assign data0 = w_data[0];
    assign data1 = w_data[1];
`ifdef CXROM_ARB_STATS_EN
    assign gnt_cnt0 = w_cnt[0];
    assign gnt_cnt1 = w_cnt[1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_oc8051_cxrom_arb.sv
// ============================================================================
// Module      : tb_oc8051_cxrom_arb
// Description : Self-checking bench for oc8051_cxrom_arb (ROM_DEPTH=1024);
//               also checks grant counters when CXROM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oc8051_cxrom_arb;

    localparam int unsigned c_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] data0, data1;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
`ifdef CXROM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who was served last cycle, who won most recently.
    bit          m_started;
    bit          m_prev [2];
    int          m_last;
    bit          m_ack  [2];
    bit          m_err  [2];
    logic [31:0] m_data [2];
    int          m_cnt  [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a ^ 16'h5A3C, ~a};
    endfunction

    assign rom_data = rom_f(rom_addr);

    oc8051_cxrom_arb #(.ROM_DEPTH(c_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .data0    (data0),
        .err0     (err0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .data1    (data1),
        .err1     (err1),
`ifdef CXROM_ARB_STATS_EN
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_last    = 1;
        for (int p = 0; p < 2; p++) begin
            m_prev[p] = 1'b0;
            m_ack[p]  = 1'b0;
            m_err[p]  = 1'b0;
            m_data[p] = '0;
            m_cnt[p]  = 0;
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".ack0"},  ack0,  m_ack[0]);
        chk({tag, ".ack1"},  ack1,  m_ack[1]);
        chk({tag, ".data0"}, data0, m_data[0]);
        chk({tag, ".data1"}, data1, m_data[1]);
        chk({tag, ".err0"},  err0,  m_err[0]);
        chk({tag, ".err1"},  err1,  m_err[1]);
`ifdef CXROM_ARB_STATS_EN
        chk({tag, ".cnt0"},  gnt_cnt0, m_cnt[0]);
        chk({tag, ".cnt1"},  gnt_cnt1, m_cnt[1]);
`endif
    endtask

    // Entered at posedge+1; applies inputs for one cycle and checks the result.
    task automatic do_cycle(input string tag, input logic r0, input logic [15:0] a0,
                            input logic r1, input logic [15:0] a1);
        bit          e0, e1;
        int          w;
        logic [15:0] wa;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
        e0 = m_started && r0 && !m_prev[0];
        e1 = m_started && r1 && !m_prev[1];
        if (e0 && e1)  w = (m_last == 0) ? 1 : 0;
        else if (e0)   w = 0;
        else if (e1)   w = 1;
        else           w = -1;
        wa = (w == 1) ? a1 : a0;
        #1;
        if (w >= 0) chk({tag, ".rom_addr"}, rom_addr, wa);
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            m_prev[p] = (w == p);
            m_ack[p]  = (w == p);
            if (w == p) begin
                m_err[p]  = (wa >= c_DEPTH);
                m_data[p] = (wa >= c_DEPTH) ? 32'h0 : rom_f(wa);
                if (m_cnt[p] < 65535) m_cnt[p]++;
            end
        end
        if (w >= 0) m_last = w;
        m_started = 1'b1;
        chk_outputs(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        model_reset();
        #1;
        chk_outputs("rst_async");
        @(posedge clk);
        #1;
        chk_outputs("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        int          acks;
        logic        cr [2];
        logic [15:0] ca [2];

        model_reset();
        #2;
        chk_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First cycle after release: no grant even with a request.
        do_cycle("norun", 1'b1, 16'h0010, 1'b0, 16'h0);
        chk("norun.ack0", ack0, 1'b0);
        do_cycle("idle", 1'b0, 16'h0, 1'b0, 16'h0);

        // Single port-0 read.
        do_cycle("rd0", 1'b1, 16'h0010, 1'b0, 16'h0);
        chk("rd0.ack0",  ack0,  1'b1);
        chk("rd0.data0", data0, 32'hDEADBEEF);
        chk("rd0.err0",  err0,  1'b0);
        chk("rd0.ack1",  ack1,  1'b0);
        do_cycle("rd0b", 1'b0, 16'h0, 1'b0, 16'h0);
        chk("hold.data0", data0, 32'hDEADBEEF);

        // Out-of-range on port 1.
        do_cycle("oor", 1'b0, 16'h0, 1'b1, 16'h0400);
        chk("oor.ack1",  ack1,  1'b1);
        chk("oor.err1",  err1,  1'b1);
        chk("oor.data1", data1, 32'h0);
        do_cycle("oorb", 1'b0, 16'h0, 1'b0, 16'h0);

        // Contention from reset release: strict alternation starting at port 0.
        apply_reset();
        do_cycle("cont_rel", 1'b1, 16'h0100, 1'b1, 16'h0200);
        for (int k = 0; k < 8; k++) begin
            do_cycle("cont", 1'b1, 16'h0100 + 16'(k), 1'b1, 16'h0200 + 16'(k));
            chk("cont.ack0", ack0, (k % 2) == 0);
            chk("cont.ack1", ack1, (k % 2) == 1);
        end
`ifdef CXROM_ARB_STATS_EN
        chk("stats.cnt0", gnt_cnt0, 16'd4);
        chk("stats.cnt1", gnt_cnt1, 16'd4);
`endif
        do_cycle("cont_end", 1'b0, 16'h0, 1'b0, 16'h0);
        do_cycle("cont_end", 1'b0, 16'h0, 1'b0, 16'h0);

        // Reset asserted in the grant cycle drops the transaction.
        req0 = 1'b1; addr0 = 16'h0020; req1 = 1'b0;
        #1;
        chk("midrst.rom_addr", rom_addr, 16'h0020);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_cycle("midrst", 1'b0, 16'h0, 1'b0, 16'h0);
            chk("midrst.ack0", ack0, 1'b0);
        end

        // Lone requester is served every other cycle.
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            do_cycle("rate", 1'b0, 16'h0, 1'b1, 16'h0033);
            if (ack1) acks++;
        end
        chk("rate.acks", acks, 5);
        do_cycle("rate_end", 1'b0, 16'h0, 1'b0, 16'h0);
        do_cycle("rate_end", 1'b0, 16'h0, 1'b0, 16'h0);

        // Random traffic; addresses held while a request is pending.
        for (int p = 0; p < 2; p++) begin cr[p] = 1'b0; ca[p] = '0; end
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (cr[p] && !m_prev[p] && ($urandom_range(0, 15) != 0)) begin
                    // pending request keeps its address
                end else begin
                    cr[p] = ($urandom_range(0, 3) != 0);
                    ca[p] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535))
                                                        : 16'($urandom_range(0, 1023));
                end
            end
            do_cycle("rand", cr[0], ca[0], cr[1], ca[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/oc8051_cxrom_arb.md
OC8051_CXROM_ARB -- requirements
Module: oc8051_cxrom_arb

Interface
REQ-001 SHALL have parameters, one per line:
- ROM_DEPTH, 65536, number of valid 32-bit words; addresses >= ROM_DEPTH are errors.
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 (CPU fetch) request.
- addr0  in  ADDR_W  port 0 address, stable while req0 is high until ack0.
- ack0  out  1  port 0 one-cycle completion pulse.
- data0  out  DATA_W  port 0 read data, valid when ack0 is high.
- err0  out  1  port 0 out-of-range flag, valid when ack0 is high.
- req1, addr1, ack1, data1, err1: same as port 0, for port 1 (secondary/boot-check engine).
- rom_addr  out  ADDR_W  combinational address to the combinational ROM.
- rom_data  in  DATA_W  combinational ROM output for rom_addr.

Function
REQ-003 SHALL make at most one grant per cycle; the winner's address drives rom_addr in the same cycle.
REQ-004 SHALL register rom_data into dataN and pulse ackN high for exactly the cycle after the grant (latency 1).
REQ-005 SHALL treat a port granted in cycle N as ineligible in cycle N+1, so one request is never served twice.
REQ-006 SHALL keep ROM throughput at one access per cycle when ports alternate.
REQ-007 SHALL arbitrate round-robin:
- Both eligible: the port not granted most recently wins.
- Only one eligible: it wins and the pointer updates.
REQ-008 SHALL drive rom_addr with addr0 when there is no grant; this is a don't-care with no side effects.
REQ-009 SHALL handle an out-of-range granted address (addr >= ROM_DEPTH): ackN still pulses, errN=1, dataN=0.
REQ-010 SHALL hold dataN and errN stable until that port's next ack; ackN is low otherwise.
REQ-011 SHALL not record a pending request when reqN deasserts before a grant.
REQ-012 SHALL define the internal FSM per port as IDLE (eligible) and ACK (ack cycle, ineligible).
- IDLE -> ACK on grant.
- ACK -> IDLE unconditionally.

Reset
REQ-013 SHALL, on rst low, immediately clear: ack0=ack1=0, data0=data1=0, err0=err1=0, both FSMs=IDLE, round-robin pointer favouring port 0.
REQ-014 SHALL drop any transaction granted in the cycle reset asserts, with no ack after reset release.
REQ-015 SHALL not grant in the first cycle after reset release; arbitration begins on the first rising edge after release.

Configuration
REQ-016 SHALL, with CXROM_ARB_STATS_EN defined, add ports gnt_cnt0 and gnt_cnt1 (out, 16 bits each).
- Each counts grants per port, saturating at 16'hFFFF.
- Each resets to 0.
REQ-017 SHALL, without CXROM_ARB_STATS_EN, omit those ports and counters entirely; function is otherwise identical.

Structure
REQ-018 SHALL take ADDR_W/DATA_W default constants and the port-index typedef from a shared package oc8051_cxrom_pkg.
REQ-019 SHALL implement arbitration in one sub-module, oc8051_rr_arb2.
- Inputs: two eligible-request bits.
- Outputs: one-hot grant and the pointer update.

Verification
REQ-020 SHALL cover a single port-0 read: req0=1, addr0=16'h0010, rom_data=32'hDEADBEEF -> next cycle ack0=1, data0=32'hDEADBEEF, err0=0; ack1 stays 0.
REQ-021 SHALL cover contention: req0 and req1 held high from reset release -> grants 0,1,0,1 on consecutive cycles; acks alternate ack0, ack1, ...; no ack on two consecutive cycles for the same port.
REQ-022 SHALL cover out-of-range with ROM_DEPTH=1024: addr1=16'h0400 -> ack1=1, err1=1, data1=0.
REQ-023 SHALL cover reset mid-operation: rst low in the grant cycle of addr0=16'h0020 -> no ack0 afterwards; all outputs 0 during reset.
REQ-024 SHALL cover the single-requester rate: req1 held high alone for 10 cycles -> exactly 5 ack1 pulses, each 1 cycle wide.
REQ-025 SHALL cover stats with CXROM_ARB_STATS_EN: after REQ-021 runs 8 cycles -> gnt_cnt0=4, gnt_cnt1=4.
